mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-port unified memory between the pipeline's instruction-fetch port (I) and its
//  load/store port (D). Sits between riscv_stub's instr/data buses and the memory.
//  Arbitrates with D priority and a starvation guard, then runs one memory transaction at a time
//  over a variable-latency req/ack handshake. Returns per-port done pulses; the core stalls on them.
// PARAMETERS
//  DATA_WIDTH    32  width of data and address buses
//  MAX_D_STREAK  4   consecutive D grants allowed while I waits before I is forced (>=1)
// PORTS
//  clk        in   1           clock, rising edge
//  reset      in   1           asynchronous, active-high
//  i_req      in   1           fetch request, held until i_done
//  i_addr     in   DATA_WIDTH  fetch address
//  i_done     out  1           1-cycle pulse: fetch complete, i_rdata valid
//  i_rdata    out  DATA_WIDTH  fetched word, registered, held until next I completion
//  d_req      in   1           load/store request, held until d_done
//  d_we       in   1           1 = store, 0 = load
//  d_addr     in   DATA_WIDTH  load/store address
//  d_wdata    in   DATA_WIDTH  store data
//  d_done     out  1           1-cycle pulse: load/store complete
//  d_rdata    out  DATA_WIDTH  load data, registered, updated on load completion only
//  mem_req    out  1           transaction active toward memory
//  mem_we     out  1           write strobe, qualified by mem_req
//  mem_addr   out  DATA_WIDTH  memory address
//  mem_wdata  out  DATA_WIDTH  memory write data
//  mem_rdata  in   DATA_WIDTH  memory read data, valid with mem_ack
//  mem_ack    in   1           1-cycle pulse: transaction complete; ignored when mem_req=0
//  busy       out  1           FSM not in IDLE
// BEHAVIOUR
//  Reset: state=IDLE. All outputs 0: mem_req/we/addr/wdata, i/d_done, i/d_rdata, busy. streak=0.
//  Async reset mid-transaction abandons it. No done pulse. Memory must tolerate mem_req dropping.
//  FSM states: IDLE, BUSY_I, BUSY_D.
//  IDLE arbitration, evaluated each cycle:
//   - d_req & i_req: grant I if streak==MAX_D_STREAK, else D.
//   - only one requester: grant it.
//   - neither: stay in IDLE.
//  Grant at edge N:
//   - The granted port's addr/we/wdata are registered onto mem_* (I forces mem_we=0).
//   - State becomes BUSY_x and mem_req=1 from cycle N+1.
//  Streak counter:
//   - D grant with i_req high: streak+1, saturating at MAX_D_STREAK.
//   - D grant with i_req low, or any I grant: streak=0.
//  BUSY_x:
//   - Hold all mem_* stable until mem_ack. Stay in state while mem_ack=0; there is no timeout.
//   - On mem_ack at edge M: state=IDLE, mem_req=0, mem_we=0, x_done=1 during cycle M+1.
//   - Loads and fetches: x_rdata <= mem_rdata at the same edge.
//   - Stores: d_rdata is unchanged.
//  Done-cycle rule: x_req during the x_done cycle is a new request. The requester drops it if idle.
//  Both ports are arbitrated in that cycle (the IDLE cycle).
//  Minimum cost per transaction with ack on the first BUSY cycle: 2 cycles, grant edge to done pulse.
//  busy = (state != IDLE).
//  Never more than one outstanding transaction.
//  i_done and d_done are never high in the same cycle.
// TESTING
//  1. Reset, then i_req with i_addr=0x0000_0004; memory acks 1 cycle after mem_req with
//     0x0010_0093 -> mem_req high 1 cycle; i_done pulse 1 cycle later; i_rdata=0x0010_0093.
//  2. i_req and d_req both high, d_we=1, d_addr=0x10, d_wdata=0xFFFF_FFFE, MAX_D_STREAK=4
//     -> D granted first, mem_we=1, d_done, d_rdata stays 0; then I is granted.
//  3. i_req held high, d_req re-asserted in every done cycle -> exactly 4 D grants,
//     then 1 I grant; streak back to 0.
//  4. Memory delays ack 5 cycles -> mem_addr/mem_wdata/mem_we stable for all 5 cycles,
//     busy=1, no done pulse early.
//  5. Reset asserted 2 cycles into BUSY_D -> outputs 0 immediately, no d_done.
//     After release, pending i_req is granted normally.
//  6. mem_ack pulsed while IDLE -> ignored: no done pulse, state unchanged.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port memory between instruction fetch (I) and load/store (D).
// D has priority; a streak counter forces an I grant after MAX_D_STREAK back-to-back D grants
// while I is waiting. One transaction at a time over a variable-latency req/ack handshake.
module mem_port_arbiter #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned MAX_D_STREAK = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  // Fetch port
  input  logic                  i_req,
  input  logic [DATA_WIDTH-1:0] i_addr,
  output logic                  i_done,
  output logic [DATA_WIDTH-1:0] i_rdata,
  // Load/store port
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [DATA_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic                  d_done,
  output logic [DATA_WIDTH-1:0] d_rdata,
  // Memory side
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ack,
  output logic                  busy
);

  localparam int unsigned            StreakW   = $clog2(MAX_D_STREAK + 1);
  localparam logic [StreakW-1:0]     StreakMax = StreakW'(MAX_D_STREAK);

  typedef enum logic [1:0] {StIdle, StBusyI, StBusyD} state_e;

  state_e                  state_q;
  logic [StreakW-1:0]      streak_q;
  logic                    i_done_q, d_done_q;
  logic [DATA_WIDTH-1:0]   i_rdata_q, d_rdata_q;
  logic                    mem_req_q, mem_we_q;
  logic [DATA_WIDTH-1:0]   mem_addr_q, mem_wdata_q;
  logic                    force_i;

  // I wins a contested cycle only once D has used up its streak allowance.
  assign force_i = i_req && (streak_q == StreakMax);

  // Arbitration, transaction sequencing and all registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      streak_q    <= '0;
      i_done_q    <= 1'b0;
      d_done_q    <= 1'b0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      i_done_q <= 1'b0;
      d_done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (d_req && !force_i) begin
            state_q     <= StBusyD;
            mem_req_q   <= 1'b1;
            mem_we_q    <= d_we;
            mem_addr_q  <= d_addr;
            mem_wdata_q <= d_wdata;
            // Streak only grows while I is actually being held off.
            if (!i_req) begin
              streak_q <= '0;
            end else if (streak_q != StreakMax) begin
              streak_q <= streak_q + 1'b1;
            end
          end else if (i_req) begin
            state_q     <= StBusyI;
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= i_addr;
            mem_wdata_q <= '0;
            streak_q    <= '0;
          end
        end
        StBusyI: begin
          if (mem_ack) begin
            state_q   <= StIdle;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            i_done_q  <= 1'b1;
            i_rdata_q <= mem_rdata;
          end
        end
        StBusyD: begin
          if (mem_ack) begin
            state_q   <= StIdle;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            d_done_q  <= 1'b1;
            // Stores leave the load data register untouched.
            if (!mem_we_q) begin
              d_rdata_q <= mem_rdata;
            end
          end
        end
        default: begin
          state_q   <= StIdle;
          mem_req_q <= 1'b0;
          mem_we_q  <= 1'b0;
        end
      endcase
    end
  end

  assign i_done    = i_done_q;
  assign d_done    = d_done_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus pushes expected memory transactions and
// expected done pulses; a memory model and a done monitor pop and compare independently.
module tb_mem_port_arbiter;

  logic        clk, reset;
  logic        i_req, d_req, d_we;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic        i_done, d_done;
  logic [31:0] i_rdata, d_rdata;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        busy;

  mem_port_arbiter #(.DATA_WIDTH(32), .MAX_D_STREAK(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .i_req    (i_req),
    .i_addr   (i_addr),
    .i_done   (i_done),
    .i_rdata  (i_rdata),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_done   (d_done),
    .d_rdata  (d_rdata),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ack  (mem_ack),
    .busy     (busy)
  );

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  typedef struct {
    bit          is_d;
    logic [31:0] rdata;
  } done_t;

  txn_t  exp_txn[$];
  done_t exp_done[$];

  int n_pass  = 0;
  int n_total = 0;
  int ack_delay = 0;
  bit force_ack = 0;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running want finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
  endtask

  task automatic fail_event(input string name);
    n_total++;
    $display("FAIL %s: got event-missing want event-seen", name);
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h4) return 32'h0010_0093;
    return a ^ 32'hA5A5_0000;
  endfunction

  // Memory model: checks each transaction and its stability, acks after ack_delay cycles.
  initial begin
    bit   active;
    int   cnt;
    txn_t cur;
    active    = 0;
    cnt       = 0;
    mem_ack   = 0;
    mem_rdata = 0;
    cur       = '{we: 0, addr: 0, wdata: 0};
    forever begin
      @(posedge clk);
      #1;
      mem_ack = 0;
      if (reset) begin
        active = 0;
        continue;
      end
      if (force_ack) begin
        force_ack = 0;
        mem_ack   = 1;
        mem_rdata = 32'h5555_5555;
        continue;
      end
      if (mem_req) begin
        if (!active) begin
          active = 1;
          cnt    = 0;
          if (exp_txn.size() == 0) fail_event("unexpected_mem_txn");
          else cur = exp_txn.pop_front();
        end
        check("mem_we", {31'b0, mem_we}, {31'b0, cur.we});
        check("mem_addr", mem_addr, cur.addr);
        if (cur.we) check("mem_wdata", mem_wdata, cur.wdata);
        check("busy_during_txn", {31'b0, busy}, 32'd1);
        if (cnt == ack_delay) begin
          mem_ack   = 1;
          mem_rdata = mem_word(mem_addr);
          active    = 0;
        end else begin
          cnt++;
        end
      end
    end
  end

  // Done monitor: every done pulse must match the next expected completion.
  initial begin
    done_t e;
    forever begin
      @(posedge clk);
      #1;
      if (i_done || d_done) begin
        check("done_exclusive", {31'b0, i_done && d_done}, 32'd0);
        if (exp_done.size() == 0) begin
          fail_event("unexpected_done");
        end else begin
          e = exp_done.pop_front();
          check("done_port_is_d", {31'b0, d_done}, {31'b0, e.is_d});
          if (e.is_d) check("d_rdata", d_rdata, e.rdata);
          else        check("i_rdata", i_rdata, e.rdata);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_any_done(output bit gi, output bit gd);
    gi = 0;
    gd = 0;
    for (int k = 0; k < 60; k++) begin
      step();
      if (i_done || d_done) begin
        gi = i_done;
        gd = d_done;
        return;
      end
    end
    fail_event("done_timeout");
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mem_req"},   {31'b0, mem_req}, 32'd0);
    check({tag, "_mem_we"},    {31'b0, mem_we},  32'd0);
    check({tag, "_mem_addr"},  mem_addr,  32'd0);
    check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    check({tag, "_i_done"},    {31'b0, i_done},  32'd0);
    check({tag, "_d_done"},    {31'b0, d_done},  32'd0);
    check({tag, "_i_rdata"},   i_rdata,   32'd0);
    check({tag, "_d_rdata"},   d_rdata,   32'd0);
    check({tag, "_busy"},      {31'b0, busy},    32'd0);
  endtask

  initial begin
    bit gi, gd;
    int n_cyc, nd;
    reset = 1; i_req = 0; d_req = 0; d_we = 0;
    i_addr = 0; d_addr = 0; d_wdata = 0;
    step(); step();
    check_all_zero("reset");
    reset = 0;
    step();

    // 1: single fetch, ack on first busy cycle.
    exp_txn.push_back('{we: 0, addr: 32'h4, wdata: 0});
    exp_done.push_back('{is_d: 0, rdata: 32'h0010_0093});
    i_addr = 32'h4; i_req = 1;
    n_cyc = 0;
    gi = 0;
    for (int k = 0; k < 40 && !gi; k++) begin
      step();
      if (mem_req) n_cyc++;
      if (i_done) gi = 1;
    end
    if (!gi) fail_event("t1_done_timeout");
    i_req = 0;
    check("t1_mem_req_cycles", n_cyc, 32'd1);
    step();
    check("t1_i_done_pulse_width", {31'b0, i_done}, 32'd0);
    check("t1_i_rdata_held", i_rdata, 32'h0010_0093);

    // 2: contention, D store wins, d_rdata unchanged, then I.
    exp_txn.push_back('{we: 1, addr: 32'h10, wdata: 32'hFFFF_FFFE});
    exp_txn.push_back('{we: 0, addr: 32'h8, wdata: 0});
    exp_done.push_back('{is_d: 1, rdata: 32'h0});
    exp_done.push_back('{is_d: 0, rdata: 32'hA5A5_0008});
    i_addr = 32'h8; i_req = 1;
    d_we = 1; d_addr = 32'h10; d_wdata = 32'hFFFF_FFFE; d_req = 1;
    for (int k = 0; k < 2; k++) begin
      wait_any_done(gi, gd);
      if (gi) i_req = 0;
      if (gd) d_req = 0;
    end
    i_req = 0; d_req = 0;
    step();

    // 3: D held in every done cycle while I waits: 4 D grants, then I, then D.
    for (int k = 0; k < 4; k++) begin
      exp_txn.push_back('{we: 0, addr: 32'h40 + 32'(4 * k), wdata: 0});
      exp_done.push_back('{is_d: 1, rdata: 32'hA5A5_0040 + 32'(4 * k)});
    end
    exp_txn.push_back('{we: 0, addr: 32'hC, wdata: 0});
    exp_done.push_back('{is_d: 0, rdata: 32'hA5A5_000C});
    exp_txn.push_back('{we: 0, addr: 32'h50, wdata: 0});
    exp_done.push_back('{is_d: 1, rdata: 32'hA5A5_0050});
    i_addr = 32'hC; i_req = 1;
    d_we = 0; d_addr = 32'h40; d_wdata = 0; d_req = 1;
    nd = 0;
    for (int k = 0; k < 6; k++) begin
      wait_any_done(gi, gd);
      if (gi) i_req = 0;
      if (gd) begin
        nd++;
        d_addr = 32'h40 + 32'(4 * nd);
        if (nd == 5) d_req = 0;
      end
    end
    i_req = 0; d_req = 0;
    step();

    // 4: slow memory, store held stable for the whole wait; d_rdata keeps last load.
    ack_delay = 5;
    exp_txn.push_back('{we: 1, addr: 32'h80, wdata: 32'h1234_5678});
    exp_done.push_back('{is_d: 1, rdata: 32'hA5A5_0050});
    d_we = 1; d_addr = 32'h80; d_wdata = 32'h1234_5678; d_req = 1;
    n_cyc = 0;
    gd = 0;
    for (int k = 0; k < 40 && !gd; k++) begin
      step();
      if (mem_req) n_cyc++;
      if (d_done) gd = 1;
    end
    if (!gd) fail_event("t4_done_timeout");
    d_req = 0;
    check("t4_mem_req_cycles", n_cyc, 32'd6);
    ack_delay = 0;
    step();

    // 5: reset two cycles into a D load abandons it; pending I then runs normally.
    ack_delay = 20;
    exp_txn.push_back('{we: 0, addr: 32'h90, wdata: 0});
    d_we = 0; d_addr = 32'h90; d_wdata = 32'hDEAD_BEEF; d_req = 1;
    i_addr = 32'h14; i_req = 1;
    gd = 0;
    for (int k = 0; k < 20 && !gd; k++) begin
      step();
      if (mem_req) gd = 1;
    end
    if (!gd) fail_event("t5_grant_timeout");
    step(); step();
    reset = 1;
    d_req = 0;
    #1;
    check_all_zero("t5_reset");
    step(); step();
    ack_delay = 0;
    exp_txn.push_back('{we: 0, addr: 32'h14, wdata: 0});
    exp_done.push_back('{is_d: 0, rdata: 32'hA5A5_0014});
    reset = 0;
    wait_any_done(gi, gd);
    check("t5_i_done_after_reset", {31'b0, gi}, 32'd1);
    i_req = 0;
    step();

    // 6: stray ack while idle is ignored.
    force_ack = 1;
    for (int k = 0; k < 3; k++) begin
      step();
      check("t6_busy", {31'b0, busy}, 32'd0);
      check("t6_mem_req", {31'b0, mem_req}, 32'd0);
      check("t6_no_done", {31'b0, i_done || d_done}, 32'd0);
    end

    step(); step();
    check("left_txn", exp_txn.size(), 32'd0);
    check("left_done", exp_done.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
